vx_issue_perf_counters: RTL and testbench
=========================================

Name: vx_issue_perf_counters

Overview:
- Issue-stage performance event accumulator. Samples per-cycle handshake signals from the ibuffer, scoreboard and dispatch ports and maintains free-running stall and active-thread counters.
- Its count outputs drive the issue-side perf-counter bundle that the CSR/perf readout logic consumes.
- Two-stage pipeline: event capture, then accumulate. This keeps popcount and wide adders off the issue critical path.

Parameters:
- NUM_THREADS, 4, width of the thread mask.
- PERF_CTR_BITS, 44, width of every counter output.
- NUM_EX_UNITS, 5, number of dispatch targets; fixed order ALU=0, LSU=1, CSR=2, FPU=3, GPU=4.

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- perf_enable  in  1  counting enable, sampled in stage 1
- perf_clear  in  1  synchronous clear of all counters
- ibuf_push_valid  in  1  decode offering an instruction to the ibuffer
- ibuf_push_ready  in  1  ibuffer accepting
- issue_valid  in  1  ibuffer head valid
- scb_ready  in  1  scoreboard: no hazard on head instruction
- unit_sel  in  NUM_EX_UNITS  one-hot target unit of head instruction
- dispatch_ready  in  NUM_EX_UNITS  per-unit dispatch ready
- issue_tmask  in  NUM_THREADS  thread mask of head instruction
- ibf_stalls, scb_stalls, alu_stalls, lsu_stalls, csr_stalls, fpu_stalls, gpu_stalls, active_threads  out  PERF_CTR_BITS each  counters

Behaviour:
- Reset is asynchronous and active-low. While reset_n=0, all counters and all stage-1 registers are 0. Release is synchronous to clk.
- Stage 1 (registered at each clk edge; all terms are ANDed with perf_enable):
  - e_ibf = ibuf_push_valid & ~ibuf_push_ready
  - e_scb = issue_valid & ~scb_ready
  - e_unit[i] = issue_valid & scb_ready & unit_sel[i] & ~dispatch_ready[i]
  - fire = issue_valid & scb_ready & |(unit_sel & dispatch_ready)
  - e_thr = fire ? popcount(issue_tmask) : 0. Width is clog2(NUM_THREADS+1).
- Stage 2: each counter adds its stage-1 flag; active_threads adds e_thr, zero-extended.
- Latency: an event in input cycle N is visible on the outputs after edge N+2.
- Events are independent: e_ibf and e_scb in the same cycle increment both counters.
- unit_sel all-zero: no unit stall and no fire.
- unit_sel multi-hot is illegal and flagged by a simulation assertion. Hardware counts each set bit independently.
- perf_clear=1 at edge N:
  - all counters become 0 and stage-1 flags are cleared at edge N;
  - events in the pipeline at that edge are dropped;
  - input events from cycle N+1 onward are counted normally.
  - Clear wins over a simultaneous increment.
- perf_enable=0 stops new captures. Events already in stage 1 still retire on the next edge.
- Wrap-around (default): a counter at 2^PERF_CTR_BITS-1 plus increment k becomes k-1 modulo 2^PERF_CTR_BITS. No sticky flag.
- Outputs are directly registered, with no combinational path from inputs.

Optional Feature:
- Macro: VX_PERF_SATURATE_EN.
- Defined: every counter saturates at all-ones. For active_threads, an add that would overflow clamps to all-ones. perf_clear still zeroes counters.
- Undefined: modulo wrap as specified above. Area is identical apart from the compare logic.

Decomposition:
- Shared package vx_perf_pkg holds:
  - unit index localparams (PERF_UNIT_ALU..PERF_UNIT_GPU)
  - NUM_EX_UNITS
  - the stage-1 event struct typedef: ibf, scb, unit[NUM_EX_UNITS], thr count
- One natural sub-module, vx_perf_ctr: a single counter with inputs clk, reset_n, clear, incr[INC_W] and output count[PERF_CTR_BITS]. It implements the wrap/saturate choice under VX_PERF_SATURATE_EN and is instantiated 8 times.

Test Plan:
- Reset, then hold ibuf_push_valid=1, ibuf_push_ready=0 for 5 cycles with everything else idle -> ibf_stalls=5 two cycles after the last stall; every other output remains 0.
- issue_valid=1, scb_ready=1, unit_sel=00010 (LSU), dispatch_ready=00000 for 3 cycles, then dispatch_ready=00010 for 1 cycle with tmask=1011 -> lsu_stalls=3, active_threads=3, alu/csr/fpu/gpu_stalls=0.
- issue_valid=1, scb_ready=0 and ibuf stall in the same cycle for 4 cycles -> scb_stalls=4 and ibf_stalls=4; no unit stall, active_threads unchanged.
- Continuous fires with tmask=1111 for 10 cycles; assert perf_clear at cycle 6 -> counter reads 0 after the clear edge, then active_threads=16 after pipeline drain (4 post-clear fires x4).
- Force a counter to 2^PERF_CTR_BITS-2 (PERF_CTR_BITS=8 build), apply 3 alu stalls -> alu_stalls=1 without the macro; 255 with VX_PERF_SATURATE_EN.
- Assert reset_n low mid-stream with counters non-zero, asynchronously between edges -> all outputs 0 immediately; after release, the first event appears two edges later.

Source files
------------

// File: rtl/vx_perf_pkg.sv
`default_nettype none
//==============================================================================
// Module : vx_perf_pkg
// Brief  : Shared constants and stage-1 event record for the issue perf counters.
// Rev    : 1.0
//==============================================================================
package vx_perf_pkg;

   localparam int NUM_EX_UNITS     = 5;
   localparam int PERF_UNIT_ALU    = 0;
   localparam int PERF_UNIT_LSU    = 1;
   localparam int PERF_UNIT_CSR    = 2;
   localparam int PERF_UNIT_FPU    = 3;
   localparam int PERF_UNIT_GPU    = 4;

   localparam int PERF_NUM_THREADS = 4;
   localparam int PERF_THR_W       = $clog2(PERF_NUM_THREADS + 1);

   typedef struct packed {
      logic                    ibf;
      logic                    scb;
      logic [NUM_EX_UNITS-1:0] unit;
      logic [PERF_THR_W-1:0]   thr;
   } perf_evt_t;

endpackage
`default_nettype wire

// File: rtl/vx_issue_perf_counters_if.sv
`default_nettype none
//==============================================================================
// Module : vx_issue_perf_counters_if
// Brief  : Issue-stage handshake bundle observed by the perf counters.
// Rev    : 1.0
//==============================================================================
interface vx_issue_perf_counters_if
   import vx_perf_pkg::*;
#(
   parameter int NUM_THREADS = PERF_NUM_THREADS
) ();

   logic                    ibuf_push_valid;
   logic                    ibuf_push_ready;
   logic                    issue_valid;
   logic                    scb_ready;
   logic [NUM_EX_UNITS-1:0] unit_sel;
   logic [NUM_EX_UNITS-1:0] dispatch_ready;
   logic [NUM_THREADS-1:0]  issue_tmask;

   modport master (
      output ibuf_push_valid, ibuf_push_ready, issue_valid, scb_ready,
             unit_sel, dispatch_ready, issue_tmask
   );

   modport slave (
      input  ibuf_push_valid, ibuf_push_ready, issue_valid, scb_ready,
             unit_sel, dispatch_ready, issue_tmask
   );

endinterface
`default_nettype wire

// File: rtl/vx_perf_ctr.sv
`default_nettype none
//==============================================================================
// Module : vx_perf_ctr
// Brief  : Single free-running event counter; wraps by default, saturates at
//          all-ones when VX_PERF_SATURATE_EN is defined.
// Rev    : 1.0
//==============================================================================
module vx_perf_ctr #(
   parameter int INC_W         = 1,
   parameter int PERF_CTR_BITS = 44
) (
   input  wire logic                     clk,
   input  wire logic                     reset_n,
   input  wire logic                     clear,
   input  wire logic [INC_W-1:0]         incr,
   output logic      [PERF_CTR_BITS-1:0] count
);

   logic [PERF_CTR_BITS-1:0] r_count;
   logic [PERF_CTR_BITS-1:0] w_next;

`ifdef VX_PERF_SATURATE_EN
   // One extra bit catches the carry so overflow clamps instead of wrapping.
   logic [PERF_CTR_BITS:0] w_sum;
   assign w_sum  = {1'b0, r_count} + (PERF_CTR_BITS+1)'(incr);
   assign w_next = w_sum[PERF_CTR_BITS] ? '1 : w_sum[PERF_CTR_BITS-1:0];
`else
   assign w_next = r_count + PERF_CTR_BITS'(incr);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else begin
         r_count <= w_next;
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/vx_issue_perf_counters.sv
`default_nettype none
//==============================================================================
// Module : vx_issue_perf_counters
// Brief  : Issue-stage stall / active-thread accumulator (capture, then add).
//          Counter overflow behaviour selected by VX_PERF_SATURATE_EN.
// Rev    : 1.0
//==============================================================================
module vx_issue_perf_counters
   import vx_perf_pkg::*;
#(
   parameter int NUM_THREADS   = PERF_NUM_THREADS,
   parameter int PERF_CTR_BITS = 44
) (
   input  wire logic                     clk,
   input  wire logic                     reset_n,
   input  wire logic                     perf_enable,
   input  wire logic                     perf_clear,
   vx_issue_perf_counters_if.slave       bus,
   output logic      [PERF_CTR_BITS-1:0] ibf_stalls,
   output logic      [PERF_CTR_BITS-1:0] scb_stalls,
   output logic      [PERF_CTR_BITS-1:0] alu_stalls,
   output logic      [PERF_CTR_BITS-1:0] lsu_stalls,
   output logic      [PERF_CTR_BITS-1:0] csr_stalls,
   output logic      [PERF_CTR_BITS-1:0] fpu_stalls,
   output logic      [PERF_CTR_BITS-1:0] gpu_stalls,
   output logic      [PERF_CTR_BITS-1:0] active_threads
);

   perf_evt_t                w_evt;
   perf_evt_t                r_evt;
   logic                     w_go;
   logic                     w_fire;
   logic [PERF_THR_W-1:0]    w_pop;
   logic [PERF_CTR_BITS-1:0] w_unit_cnt [NUM_EX_UNITS];

   // Stage 1: flatten the handshakes into single-cycle event flags.
   always_comb begin
      w_evt    = '0;
      w_go     = bus.issue_valid & bus.scb_ready;
      w_fire   = w_go & (|(bus.unit_sel & bus.dispatch_ready));
      w_pop    = '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         w_pop = w_pop + PERF_THR_W'(bus.issue_tmask[i]);
      end
      w_evt.ibf  = perf_enable & bus.ibuf_push_valid & ~bus.ibuf_push_ready;
      w_evt.scb  = perf_enable & bus.issue_valid & ~bus.scb_ready;
      w_evt.unit = {NUM_EX_UNITS{perf_enable & w_go}} & bus.unit_sel & ~bus.dispatch_ready;
      w_evt.thr  = (perf_enable & w_fire) ? w_pop : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_evt <= '0;
      end else if (perf_clear) begin
         r_evt <= '0;
      end else begin
         r_evt <= w_evt;
      end
   end

   // Stage 2: one accumulator per event class.
   vx_perf_ctr #(.INC_W(1), .PERF_CTR_BITS(PERF_CTR_BITS)) u_ctr_ibf (
      .clk(clk), .reset_n(reset_n), .clear(perf_clear), .incr(r_evt.ibf), .count(ibf_stalls)
   );

   vx_perf_ctr #(.INC_W(1), .PERF_CTR_BITS(PERF_CTR_BITS)) u_ctr_scb (
      .clk(clk), .reset_n(reset_n), .clear(perf_clear), .incr(r_evt.scb), .count(scb_stalls)
   );

   generate
      for (genvar g = 0; g < NUM_EX_UNITS; g++) begin : g_unit
         vx_perf_ctr #(.INC_W(1), .PERF_CTR_BITS(PERF_CTR_BITS)) u_ctr_unit (
            .clk(clk), .reset_n(reset_n), .clear(perf_clear),
            .incr(r_evt.unit[g]), .count(w_unit_cnt[g])
         );
      end
   endgenerate

   vx_perf_ctr #(.INC_W(PERF_THR_W), .PERF_CTR_BITS(PERF_CTR_BITS)) u_ctr_thr (
      .clk(clk), .reset_n(reset_n), .clear(perf_clear), .incr(r_evt.thr), .count(active_threads)
   );

   assign alu_stalls = w_unit_cnt[PERF_UNIT_ALU];
   assign lsu_stalls = w_unit_cnt[PERF_UNIT_LSU];
   assign csr_stalls = w_unit_cnt[PERF_UNIT_CSR];
   assign fpu_stalls = w_unit_cnt[PERF_UNIT_FPU];
   assign gpu_stalls = w_unit_cnt[PERF_UNIT_GPU];

   // Multi-hot targets are counted bit-by-bit in hardware but are illegal.
   always @(posedge clk) begin
      if (reset_n && bus.issue_valid) begin
         assert ($onehot0(bus.unit_sel));
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vx_issue_perf_counters.sv
`default_nettype none
//==============================================================================
// Module : tb_vx_issue_perf_counters
// Brief  : Directed plus random bench for vx_issue_perf_counters (8-bit build).
// Rev    : 1.0
//==============================================================================
module tb_vx_issue_perf_counters;

   localparam int W    = 8;
   localparam int MAXV = (1 << W) - 1;
   localparam int NC   = 8;
   localparam int K_IBF = 0, K_SCB = 1, K_UNIT0 = 2, K_THR = 7;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         perf_enable;
   logic         perf_clear;
   logic [W-1:0] ibf_stalls, scb_stalls, alu_stalls, lsu_stalls;
   logic [W-1:0] csr_stalls, fpu_stalls, gpu_stalls, active_threads;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt [NC];
   int pend    [NC];
   string names [NC] = '{"ibf", "scb", "alu", "lsu", "csr", "fpu", "gpu", "thr"};

   vx_issue_perf_counters_if #(.NUM_THREADS(4)) bus ();

   vx_issue_perf_counters #(.NUM_THREADS(4), .PERF_CTR_BITS(W)) dut (
      .clk(clk), .reset_n(reset_n), .perf_enable(perf_enable), .perf_clear(perf_clear),
      .bus(bus),
      .ibf_stalls(ibf_stalls), .scb_stalls(scb_stalls), .alu_stalls(alu_stalls),
      .lsu_stalls(lsu_stalls), .csr_stalls(csr_stalls), .fpu_stalls(fpu_stalls),
      .gpu_stalls(gpu_stalls), .active_threads(active_threads)
   );

   always #5 clk = ~clk;

   function automatic int acc(int a, int k);
`ifdef VX_PERF_SATURATE_EN
      return (a + k > MAXV) ? MAXV : a + k;
`else
      return (a + k) % (MAXV + 1);
`endif
   endfunction

   function automatic logic [W-1:0] dut_val(int k);
      case (k)
         0: return ibf_stalls;
         1: return scb_stalls;
         2: return alu_stalls;
         3: return lsu_stalls;
         4: return csr_stalls;
         5: return fpu_stalls;
         6: return gpu_stalls;
         default: return active_threads;
      endcase
   endfunction

   task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic check_all(string tag);
      for (int k = 0; k < NC; k++) check($sformatf("%s/%s", tag, names[k]), dut_val(k), W'(exp_cnt[k]));
   endtask

   // Reference: events seen at an edge become visible one edge later.
   task automatic model_edge();
      if (!reset_n || perf_clear) begin
         for (int k = 0; k < NC; k++) begin exp_cnt[k] = 0; pend[k] = 0; end
         return;
      end
      for (int k = 0; k < NC; k++) begin
         exp_cnt[k] = acc(exp_cnt[k], pend[k]);
         pend[k]    = 0;
      end
      if (!perf_enable) return;
      pend[K_IBF] = int'(bus.ibuf_push_valid && !bus.ibuf_push_ready);
      pend[K_SCB] = int'(bus.issue_valid && !bus.scb_ready);
      for (int u = 0; u < 5; u++)
         pend[K_UNIT0+u] = int'(bus.issue_valid && bus.scb_ready && bus.unit_sel[u] && !bus.dispatch_ready[u]);
      if (bus.issue_valid && bus.scb_ready && (bus.unit_sel & bus.dispatch_ready) != 0)
         pend[K_THR] = $countones(bus.issue_tmask);
   endtask

   task automatic tick(string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic idle();
      bus.ibuf_push_valid = 0; bus.ibuf_push_ready = 1; bus.issue_valid = 0;
      bus.scb_ready = 1; bus.unit_sel = '0; bus.dispatch_ready = '1;
      bus.issue_tmask = '0; perf_clear = 0; perf_enable = 1;
   endtask

   task automatic do_clear();
      idle(); perf_clear = 1; tick("clear"); perf_clear = 0;
   endtask

   task automatic rand_inputs();
      int s;
      bus.ibuf_push_valid = 1'($urandom);
      bus.ibuf_push_ready = 1'($urandom);
      bus.issue_valid     = 1'($urandom);
      bus.scb_ready       = ($urandom_range(0, 3) != 0);
      s = $urandom_range(0, 5);
      bus.unit_sel        = (s == 5) ? 5'b0 : 5'(1 << s);
      bus.dispatch_ready  = 5'($urandom);
      bus.issue_tmask     = 4'($urandom);
      perf_enable         = ($urandom_range(0, 7) != 0);
      perf_clear          = ($urandom_range(0, 39) == 0);
   endtask

   initial begin
      for (int k = 0; k < NC; k++) begin exp_cnt[k] = 0; pend[k] = 0; end
      reset_n = 0;
      idle();
      tick("reset0"); tick("reset1");
      reset_n = 1;

      // Five ibuffer stalls, then drain.
      do_clear();
      bus.ibuf_push_valid = 1; bus.ibuf_push_ready = 0;
      for (int i = 0; i < 5; i++) tick("ibf");
      idle(); tick("ibf_d0"); tick("ibf_d1");
      check("ibf_total", ibf_stalls, 8'd5);

      // LSU blocked three cycles, then fires with tmask 1011.
      do_clear();
      bus.issue_valid = 1; bus.scb_ready = 1; bus.unit_sel = 5'b00010; bus.dispatch_ready = 5'b00000;
      bus.issue_tmask = 4'b1011;
      for (int i = 0; i < 3; i++) tick("lsu");
      bus.dispatch_ready = 5'b00010; tick("lsu_fire");
      idle(); tick("lsu_d0"); tick("lsu_d1");
      check("lsu_total", lsu_stalls, 8'd3);
      check("lsu_thr", active_threads, 8'd3);
      check("lsu_alu", alu_stalls, 8'd0);

      // Scoreboard and ibuffer stalls in the same cycles.
      do_clear();
      bus.issue_valid = 1; bus.scb_ready = 0; bus.unit_sel = 5'b00001; bus.dispatch_ready = 5'b00000;
      bus.ibuf_push_valid = 1; bus.ibuf_push_ready = 0; bus.issue_tmask = 4'b1111;
      for (int i = 0; i < 4; i++) tick("scb");
      idle(); tick("scb_d0"); tick("scb_d1");
      check("scb_total", scb_stalls, 8'd4);
      check("scb_ibf", ibf_stalls, 8'd4);
      check("scb_thr", active_threads, 8'd0);

      // Continuous fires with a clear on the sixth cycle.
      do_clear();
      bus.issue_valid = 1; bus.scb_ready = 1; bus.unit_sel = 5'b00100; bus.dispatch_ready = 5'b00100;
      bus.issue_tmask = 4'b1111;
      for (int i = 0; i < 10; i++) begin
         perf_clear = (i == 5);
         tick("fire");
         if (i == 5) check("fire_cleared", active_threads, 8'd0);
      end
      idle(); tick("fire_d0"); tick("fire_d1");
      check("fire_total", active_threads, 8'd16);

      // Drive the ALU counter to 2^W-2, then three more stalls.
      do_clear();
      bus.issue_valid = 1; bus.scb_ready = 1; bus.unit_sel = 5'b00001; bus.dispatch_ready = 5'b00000;
      for (int i = 0; i < MAXV - 1 + 3; i++) tick("wrap");
      idle(); tick("wrap_d0"); tick("wrap_d1");
`ifdef VX_PERF_SATURATE_EN
      check("alu_limit", alu_stalls, 8'd255);
`else
      check("alu_limit", alu_stalls, 8'd1);
`endif

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         rand_inputs();
         tick("rand");
      end

      // Asynchronous reset between edges with live counters.
      idle(); bus.ibuf_push_valid = 1; bus.ibuf_push_ready = 0;
      for (int i = 0; i < 3; i++) tick("pre_rst");
      idle(); tick("pre_rst_d0"); tick("pre_rst_d1");
      #2 reset_n = 0;
      #1 for (int k = 0; k < NC; k++) begin exp_cnt[k] = 0; pend[k] = 0; end
      check_all("async_rst");
      tick("in_rst");
      #2 reset_n = 1;
      bus.ibuf_push_valid = 1; bus.ibuf_push_ready = 0;
      tick("post_rst0");
      check("post_rst_e1", ibf_stalls, 8'd0);
      idle(); tick("post_rst1");
      check("post_rst_e2", ibf_stalls, 8'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
